mem_stage: RTL and testbench

- Memory-access pipeline stage. Sits between EX_MEM and MEM_WB.
- Consumes the EX result bundle: instIdx, memAddr, valStore, rd info.
- Performs byte-serial loads and stores over the 8-bit memory-controller port, sign- or zero-extends load data, and stalls the pipeline while an access is in flight.
- Non-memory instructions pass through with zero added latency.

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte-serial loads/stores over an 8-bit controller port,
// stalling upstream while an access is in flight. Optional perf counters: MEM_PERF_CNT_EN.
`ifndef idNOP
`define idNOP 0
`define idLB  1
`define idLH  2
`define idLW  3
`define idLBU 4
`define idLHU 5
`define idSB  6
`define idSH  7
`define idSW  8
`endif

module mem_stage #(
  parameter int INST_IDX_W = 6
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INST_IDX_W-1:0] instIdx_in,
  input  logic [31:0]           memAddr_in,
  input  logic [31:0]           valStore_in,
  input  logic                  rdE_in,
  input  logic [4:0]            rdIdx_in,
  input  logic [31:0]           rdData_in,
  output logic                  memReq_out,
  output logic                  memWr_out,
  output logic [31:0]           memAddr_out,
  output logic [7:0]            memWData_out,
  input  logic                  memDone_in,
  input  logic [7:0]            memRData_in,
  output logic                  stallReq_out,
  output logic                  rdE_out,
  output logic [4:0]            rdIdx_out,
  output logic [31:0]           rdData_out,
  output logic [1:0]            dbg_state_out
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]           loadCnt_out,
  output logic [31:0]           storeCnt_out,
  output logic [31:0]           stallCyc_out
`endif
);

  localparam logic [INST_IDX_W-1:0] ID_LB  = INST_IDX_W'(`idLB);
  localparam logic [INST_IDX_W-1:0] ID_LH  = INST_IDX_W'(`idLH);
  localparam logic [INST_IDX_W-1:0] ID_LW  = INST_IDX_W'(`idLW);
  localparam logic [INST_IDX_W-1:0] ID_LBU = INST_IDX_W'(`idLBU);
  localparam logic [INST_IDX_W-1:0] ID_LHU = INST_IDX_W'(`idLHU);
  localparam logic [INST_IDX_W-1:0] ID_SB  = INST_IDX_W'(`idSB);
  localparam logic [INST_IDX_W-1:0] ID_SH  = INST_IDX_W'(`idSH);
  localparam logic [INST_IDX_W-1:0] ID_SW  = INST_IDX_W'(`idSW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  cnt_q;
  logic [31:0] ld_buf_q;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [1:0]  last_idx;
  logic [31:0] ld_ext;

  // Instruction stays stable on instIdx_in while stalled, so it is decoded live.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    last_idx = 2'd0;
    case (instIdx_in)
      ID_LB, ID_LBU: is_load = 1'b1;
      ID_LH, ID_LHU: begin is_load = 1'b1; last_idx = 2'd1; end
      ID_LW:         begin is_load = 1'b1; last_idx = 2'd3; end
      ID_SB:         is_store = 1'b1;
      ID_SH:         begin is_store = 1'b1; last_idx = 2'd1; end
      ID_SW:         begin is_store = 1'b1; last_idx = 2'd3; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

  always_comb begin
    case (instIdx_in)
      ID_LB:   ld_ext = {{24{ld_buf_q[7]}}, ld_buf_q[7:0]};
      ID_LH:   ld_ext = {{16{ld_buf_q[15]}}, ld_buf_q[15:0]};
      ID_LBU:  ld_ext = {24'h0, ld_buf_q[7:0]};
      ID_LHU:  ld_ext = {16'h0, ld_buf_q[15:0]};
      default: ld_ext = ld_buf_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_mem) state_d = BUSY;
      BUSY:    if (memDone_in && (cnt_q == last_idx)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q    <= 2'd0;
      ld_buf_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (is_mem) begin
          cnt_q    <= 2'd0;
          ld_buf_q <= 32'h0;
        end
        BUSY: if (memDone_in) begin
          if (is_load) ld_buf_q[{cnt_q, 3'b000} +: 8] <= memRData_in;
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low while reset is held so an abandoned access issues nothing.
  always_comb begin
    memReq_out   = 1'b0;
    memWr_out    = 1'b0;
    memAddr_out  = 32'h0;
    memWData_out = 8'h0;
    stallReq_out = 1'b0;
    rdE_out      = 1'b0;
    rdIdx_out    = 5'd0;
    rdData_out   = 32'h0;
    if (!rst_in) begin
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            stallReq_out = 1'b1;
          end else begin
            rdE_out    = rdE_in;
            rdIdx_out  = rdIdx_in;
            rdData_out = rdData_in;
          end
        end
        BUSY: begin
          memReq_out   = 1'b1;
          memWr_out    = is_store;
          memAddr_out  = memAddr_in + {30'h0, cnt_q};
          memWData_out = valStore_in[{cnt_q, 3'b000} +: 8];
          stallReq_out = 1'b1;
        end
        DONE: begin
          if (is_load) begin
            rdE_out    = rdE_in;
            rdIdx_out  = rdIdx_in;
            rdData_out = ld_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state_out = state_q;

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      loadCnt_out  <= 32'h0;
      storeCnt_out <= 32'h0;
      stallCyc_out <= 32'h0;
    end else begin
      if (state_q == DONE && is_load)  loadCnt_out  <= loadCnt_out + 32'd1;
      if (state_q == DONE && is_store) storeCnt_out <= storeCnt_out + 32'd1;
      if (stallReq_out)                stallCyc_out <= stallCyc_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: a byte memory responder, a driver with a reference
// model that queues expected accesses/results, and a monitor that pops and compares.
`ifndef idNOP
`define idNOP 0
`define idLB  1
`define idLH  2
`define idLW  3
`define idLBU 4
`define idLHU 5
`define idSB  6
`define idSH  7
`define idSW  8
`endif

module tb_mem_stage;

  localparam int OP_NOP = `idNOP;
  localparam int OP_LB  = `idLB;
  localparam int OP_LH  = `idLH;
  localparam int OP_LW  = `idLW;
  localparam int OP_LBU = `idLBU;
  localparam int OP_LHU = `idLHU;
  localparam int OP_SB  = `idSB;
  localparam int OP_SH  = `idSH;
  localparam int OP_SW  = `idSW;
  localparam int OP_ADD = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  inst = 6'd0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] vstore = 32'h0;
  logic        rde_in = 1'b0;
  logic [4:0]  rdi_in = 5'd0;
  logic [31:0] rdd_in = 32'h0;
  logic        mem_req, mem_wr, mem_done, stall, rde, rdE_dummy;
  logic [31:0] mem_addr, rdd;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [4:0]  rdi;
  logic [1:0]  dbg_state;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] load_cnt, store_cnt, stall_cyc;
  int          exp_loads = 0, exp_stores = 0, exp_stall = 0;
`endif

  mem_stage #(.INST_IDX_W(6)) dut (
    .clk_in(clk), .rst_in(rst), .instIdx_in(inst), .memAddr_in(addr_in),
    .valStore_in(vstore), .rdE_in(rde_in), .rdIdx_in(rdi_in), .rdData_in(rdd_in),
    .memReq_out(mem_req), .memWr_out(mem_wr), .memAddr_out(mem_addr),
    .memWData_out(mem_wdata), .memDone_in(mem_done), .memRData_in(mem_rdata),
    .stallReq_out(stall), .rdE_out(rde), .rdIdx_out(rdi), .rdData_out(rdd),
    .dbg_state_out(dbg_state)
`ifdef MEM_PERF_CNT_EN
    , .loadCnt_out(load_cnt), .storeCnt_out(store_cnt), .stallCyc_out(stall_cyc)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [40:0] exp_acc_q[$];   // {wr, addr, wdata (0 for reads)}
  logic [54:0] exp_q[$];       // {stall cycles, rdE, rdIdx, rdData, memReq}
  logic [7:0]  mem_arr [logic [31:0]];
  int          delay = 0;
  bit          spurious = 0;
  bit          active = 0;
  int          acc_cnt = 0;
  int          stall_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // reference model
  function automatic int nbytes(input int op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_store(input int op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [31:0] load_ext(input int op, input logic [31:0] w);
    int v;
    case (op)
      OP_LB:  begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
      OP_LH:  begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
      OP_LBU: return w & 32'hFF;
      OP_LHU: return w & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // memory controller responder
  int wait_cnt = 0;
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 8'h0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= delay) begin
          wait_cnt = 0;
          mem_done = 1'b1;
          if (mem_wr) begin
            mem_arr[mem_addr] = mem_wdata;
          end else begin
            if (!mem_arr.exists(mem_addr)) mem_arr[mem_addr] = 8'($urandom);
            mem_rdata = mem_arr[mem_addr];
          end
          acc_cnt++;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spurious && ($urandom_range(0, 1) == 1)) begin
          mem_done  = 1'b1;
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [40:0] ea;
    logic [54:0] er;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (mem_req && mem_done) begin
          if (exp_acc_q.size() == 0) begin
            check("unexpected_access", {23'h0, mem_wr, mem_addr, mem_wdata}, 64'h0);
          end else begin
            ea = exp_acc_q.pop_front();
            check("access", {23'h0, mem_wr, mem_addr, (mem_wr ? mem_wdata : 8'h00)}, {23'h0, ea});
          end
        end
        if (active) begin
          if (stall) begin
            stall_run++;
            check("rde_during_stall", {63'h0, rde}, 64'h0);
          end else begin
            if (exp_q.size() == 0) begin
              check("unexpected_result", {32'h0, rdd}, 64'h0);
            end else begin
              er = exp_q.pop_front();
              check("result", {9'h0, 16'(stall_run), rde, rdi, rdd, mem_req}, {9'h0, er});
            end
            stall_run = 0;
          end
        end
      end
    end
  end

  // driver
  task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] vs,
                       input logic re, input logic [4:0] ri, input logic [31:0] rdv, input int d);
    int n, sc;
    logic [31:0] a, word, res;
    logic e_re;
    logic [4:0] e_ri;
    n = nbytes(op);
    word = 32'h0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      if (is_store(op)) begin
        exp_acc_q.push_back({1'b1, a, vs[8*k +: 8]});
      end else begin
        if (!mem_arr.exists(a)) mem_arr[a] = 8'($urandom);
        word = word | (32'(mem_arr[a]) << (8 * k));
        exp_acc_q.push_back({1'b0, a, 8'h00});
      end
    end
    if (n == 0) begin
      sc = 0; e_re = re; e_ri = ri; res = rdv;
    end else begin
      sc = 1 + n * (d + 1);
      if (is_store(op)) begin e_re = 1'b0; e_ri = 5'd0; res = 32'h0; end
      else begin e_re = re; e_ri = ri; res = load_ext(op, word); end
    end
    exp_q.push_back({16'(sc), e_re, e_ri, res, 1'b0});
`ifdef MEM_PERF_CNT_EN
    exp_stall += sc;
    if (n != 0 && is_store(op)) exp_stores++;
    if (n != 0 && !is_store(op)) exp_loads++;
`endif
    @(negedge clk);
    delay = d; inst = 6'(op); addr_in = addr; vstore = vs;
    rde_in = re; rdi_in = ri; rdd_in = rdv; active = 1;
    #2;
    for (int c = 0; c < 200 && stall; c++) begin
      @(negedge clk);
      #2;
    end
    if (stall) begin
      check("timeout", 64'd1, 64'd0);
      exp_q.delete();
      exp_acc_q.delete();
    end
    active = 0;
  endtask

  initial begin
    int ops[11];
    int op, base;
    logic [31:0] ra;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_NOP, OP_ADD, OP_LW};

    // reset with a memory op presented: outputs must stay quiet
    inst = 6'(OP_LW); rde_in = 1'b1; rdi_in = 5'd7; rdd_in = 32'h1234;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {60'h0, mem_req, stall, rde, 1'b0}, 64'h0);
    check("reset_rd", {27'h0, rdi, rdd}, 64'h0);
    check("reset_state", {62'h0, dbg_state}, 64'h0);
    inst = 6'(OP_NOP); rde_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    mem_arr[32'h1000] = 8'h78; mem_arr[32'h1001] = 8'h56;
    mem_arr[32'h1002] = 8'h34; mem_arr[32'h1003] = 8'h12;
    issue(OP_LW, 32'h1000, 32'h0, 1'b1, 5'd3, 32'hDEAD, 0);
    mem_arr[32'h20] = 8'h80;
    issue(OP_LB, 32'h20, 32'h0, 1'b1, 5'd4, 32'h0, 0);
    issue(OP_LBU, 32'h20, 32'h0, 1'b1, 5'd4, 32'h0, 0);
    mem_arr[32'h40] = 8'h34; mem_arr[32'h41] = 8'hF2;
    issue(OP_LHU, 32'h40, 32'h0, 1'b1, 5'd6, 32'h0, 1);
    issue(OP_LH, 32'h40, 32'h0, 1'b1, 5'd0, 32'h0, 0);
    issue(OP_SH, 32'h2002, 32'hAABBCCDD, 1'b1, 5'd9, 32'h77, 0);
    issue(OP_ADD, 32'h0, 32'h0, 1'b1, 5'd5, 32'h55, 0);
    spurious = 1;
    issue(OP_LW, 32'h1000, 32'h0, 1'b1, 5'd8, 32'h0, 3);
    spurious = 0;
    issue(OP_LB, 32'h2002, 32'h0, 1'b1, 5'd10, 32'h0, 0);
    issue(OP_LW, 32'hFFFFFFFE, 32'h0, 1'b1, 5'd11, 32'h0, 0);

    // reset in the middle of an SW, after two bytes complete
    @(negedge clk);
    delay = 0;
    exp_acc_q.push_back({1'b1, 32'h3000, 8'h44});
    exp_acc_q.push_back({1'b1, 32'h3001, 8'h33});
    inst = 6'(OP_SW); addr_in = 32'h3000; vstore = 32'h11223344; rde_in = 1'b1;
    base = acc_cnt;
    for (int c = 0; c < 50 && (acc_cnt - base) < 2; c++) begin
      @(negedge clk);
      #2;
    end
    check("sw_two_bytes", 64'(acc_cnt - base), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_outputs", {60'h0, mem_req, stall, rde, mem_wr}, 64'h0);
    check("midreset_rd", {27'h0, rdi, rdd}, 64'h0);
    check("midreset_state", {62'h0, dbg_state}, 64'h0);
    @(negedge clk);
    inst = 6'(OP_NOP); rde_in = 1'b0; rdi_in = 5'd0; rdd_in = 32'h0;
    #1;
    rst = 1'b0;
`ifdef MEM_PERF_CNT_EN
    exp_loads = 0; exp_stores = 0; exp_stall = 0;
`endif
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_reset_idle", {61'h0, mem_req, stall, dbg_state == 2'd0}, 64'd1);
    end
    check("leftover_access", 64'(exp_acc_q.size()), 64'd0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 10)];
      ra = ($urandom_range(0, 5) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                       : {24'h0, 8'($urandom)};
      spurious = ($urandom_range(0, 2) == 0);
      issue(op, ra, $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3));
    end
    spurious = 0;
    repeat (2) @(negedge clk);
    check("final_exp_q", 64'(exp_q.size()), 64'd0);
    check("final_acc_q", 64'(exp_acc_q.size()), 64'd0);
`ifdef MEM_PERF_CNT_EN
    check("load_cnt", {32'h0, load_cnt}, 64'(exp_loads));
    check("store_cnt", {32'h0, store_cnt}, 64'(exp_stores));
    check("stall_cyc", {32'h0, stall_cyc}, 64'(exp_stall));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  assign rdE_dummy = 1'b0;

endmodule
